// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR.
// It supports step enable, runtime seed load with zero-seed fallback,
// and on-chip measurement of the sequence period.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out,
    output logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] step_cnt,
    output logic [WIDTH-1:0] period,
    output logic             period_pulse,
    output logic             seed_err
);

    logic [WIDTH-1:0] reg_q,      reg_d;
    logic [WIDTH-1:0] start_q,    start_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic             period_pulse_q, period_pulse_d;
    logic             seed_err_q,     seed_err_d;

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic             seed_zero;

    // One LFSR step from the current state in both structures; MODE selects which is used.
    always_comb begin
        fib_fb    = ^(reg_q & TAPS);
        fib_next  = {reg_q[WIDTH-2:0], fib_fb};
        gal_next  = {reg_q[WIDTH-2:0], 1'b0} ^ (reg_q[WIDTH-1] ? TAPS : '0);
        step_next = (MODE == 1) ? gal_next : fib_next;
        seed_zero = (seed_in == '0);
    end

    // Next-state selection with priority load > en > hold, plus period tracking.
    always_comb begin
        reg_d          = reg_q;
        start_d        = start_q;
        step_cnt_d     = step_cnt_q;
        period_d       = period_q;
        period_pulse_d = 1'b0;
        seed_err_d     = 1'b0;
        if (load) begin
            step_cnt_d = '0;
            if (seed_zero) begin
                reg_d      = SEED;
                start_d    = SEED;
                seed_err_d = 1'b1;
            end else begin
                reg_d   = seed_in;
                start_d = seed_in;
            end
        end else if (en) begin
            reg_d = step_next;
            if (step_next == start_q) begin
                step_cnt_d     = '0;
                period_d       = step_cnt_q + WIDTH'(1);
                period_pulse_d = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + WIDTH'(1);
            end
        end
    end

    // State registers; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_q          <= SEED;
            start_q        <= SEED;
            step_cnt_q     <= '0;
            period_q       <= '0;
            period_pulse_q <= 1'b0;
            seed_err_q     <= 1'b0;
        end else begin
            reg_q          <= reg_d;
            start_q        <= start_d;
            step_cnt_q     <= step_cnt_d;
            period_q       <= period_d;
            period_pulse_q <= period_pulse_d;
            seed_err_q     <= seed_err_d;
        end
    end

    assign reg_out      = reg_q;
    assign out          = reg_q[WIDTH-1];
    assign step_cnt     = step_cnt_q;
    assign period       = period_q;
    assign period_pulse = period_pulse_q;
    assign seed_err     = seed_err_q;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised pseudo-random sequence generator; successor to the fixed 5-bit shift-register LFSR.
- Adds:
  - configurable width, tap mask and reset seed
  - Fibonacci or Galois structure
  - step enable
  - runtime seed load with all-zero protection
  - on-chip period measurement
- Feeds BIST pattern sources and power-management stimulus blocks.

Parameters:
- WIDTH, 16, state width in bits (3..32).
- TAPS, 16'hB400, tap mask of WIDTH bits.
  - Fibonacci: bit i=1 means reg_out[i] enters the feedback XOR.
  - Galois: feedback polynomial without the x^WIDTH term; bit0 must be 1.
- SEED, 1, reset/fallback state; nonzero, WIDTH bits.
- MODE, 0, 0=Fibonacci, 1=Galois.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  advance one step this cycle.
- load  in  1  load seed_in this cycle; has priority over en.
- seed_in  in  WIDTH  runtime seed.
- out  out  1  serial output, always reg_out[WIDTH-1].
- reg_out  out  WIDTH  current state.
- step_cnt  out  WIDTH  enabled steps since last start point.
- period  out  WIDTH  last measured period; 0 = none yet.
- period_pulse  out  1  one-cycle pulse when the sequence returns to its start value.
- seed_err  out  1  one-cycle pulse when a zero seed was rejected.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - reg_out=SEED, start register=SEED
  - step_cnt=0, period=0
  - period_pulse=0, seed_err=0
- Release of reset is synchronous to clk.
- Fibonacci step:
  - fb = XOR over i of (reg_out[i] & TAPS[i]).
  - next = {reg_out[WIDTH-2:0], fb}.
- Galois step:
  - fb = reg_out[WIDTH-1].
  - next = {reg_out[WIDTH-2:0],1'b0} ^ (fb ? TAPS : 0).
- Priority each cycle is load > en > hold.
- Load, seed_in != 0:
  - reg_out=seed_in, start=seed_in, step_cnt=0.
  - period unchanged; no pulse.
- Load, seed_in == 0:
  - reg_out=SEED, start=SEED, step_cnt=0.
  - seed_err=1 for exactly that following cycle.
- en=1, load=0:
  - reg_out=next.
  - If next == start: step_cnt=0, period=step_cnt+1, period_pulse=1 the following cycle.
  - Otherwise: step_cnt=step_cnt+1, wrapping modulo 2^WIDTH.
- en=0, load=0: all state holds; pulses deassert.
- Pulse timing:
  - period_pulse and seed_err are registered.
  - Each is high for exactly one cycle after the triggering edge.
  - Never high simultaneously: load suppresses the step.
- The all-zero state is unreachable: reset and load never produce it, and a nonzero state never steps to zero for a valid TAPS.
- Latency: a step or load is visible on reg_out/out one clock after the sampling edge. out is combinational from reg_out.
- Reset asserted mid-sequence: immediate return to reset values; no pulse emitted.
- Non-primitive TAPS: sequence still cycles; period reports the actual cycle length from the start value.

Test Plan:
- Fibonacci sequence:
  - Stimulus: WIDTH=5, TAPS=5'b10010, SEED=5'b00001, MODE=0, en=1 after reset.
  - Required: reg_out = 00001, 00010, 00101, 01010, 10101, 01011 …
  - Required: period_pulse after step 31; period=31; step_cnt back to 0.
- Galois sequence:
  - Stimulus: WIDTH=5, TAPS=5'b00101, MODE=1, SEED=1, en=1.
  - Required: reg_out = 00001, 00010, 00100, 01000, 10000, 00101 …
  - Required: period=31 at first pulse.
- Load and priority:
  - Stimulus: mid-run, load=1 with en=1, seed_in=5'b10110.
  - Required: next reg_out=10110, step_cnt=0, no step applied.
  - Required: period_pulse 31 enabled steps later.
- Zero seed:
  - Stimulus: load=1, seed_in=0.
  - Required: reg_out=SEED, seed_err high exactly one cycle, step_cnt=0, period unchanged.
- Enable gating and reset:
  - Stimulus: toggle en with pattern 1,0,0,1.
  - Required: reg_out advances exactly twice; step_cnt=2.
  - Stimulus: assert rst low between clock edges.
  - Required: reg_out=SEED, period=0 immediately, without waiting for clk.
- Default 16-bit configuration:
  - Stimulus: defaults, en=1 for 65535 steps.
  - Required: single period_pulse, period=65535, reg_out=0001 at that point, no all-zero state ever observed.
